// File: rtl/bot_upd_handshake.sv
// ---------------------------------------------------------------------------
// bot_upd_handshake
//
// Handshake and snapshot stage between rojobot31 and the SweRVolf GPIO /
// interrupt path.
//
// Each rising edge of the rojobot register-update strobe becomes a level
// request (o_botupdt_sync) towards software. A coherent copy of the botinfo
// registers is frozen in o_botinfo_snap for that request. Software clears
// the request with i_int_ack. One update that arrives during the acknowledge
// is buffered and re-presented once the ack is released. Side outputs count
// update edges, count overwritten (lost) updates, and flag a request that
// waited too long for an ack.
//
// Ports
//   clk             in   1       bot clock, all logic on posedge
//   rstn            in   1       asynchronous reset, active-low
//   i_upd_sysregs   in   1       rojobot update strobe (rising edge used)
//   i_botinfo       in   INFO_W  live rojobot registers
//   i_int_ack       in   1       software acknowledge (level)
//   o_botupdt_sync  out  1       update pending to software (level)
//   o_botinfo_snap  out  INFO_W  botinfo captured for the pending update
//   o_upd_cnt       out  CNT_W   update edges seen, wraps
//   o_ovr_cnt       out  CNT_W   updates lost to overwrite, saturates
//   o_timeout       out  1       sticky: request waited ACK_TIMEOUT cycles
// ---------------------------------------------------------------------------
module bot_upd_handshake #(
    parameter int INFO_W      = 32,
    parameter int CNT_W       = 16,
    parameter int ACK_TIMEOUT = 0,
    parameter int TO_W        = 24
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_upd_sysregs,
    input  logic [INFO_W-1:0] i_botinfo,
    input  logic              i_int_ack,
    output logic              o_botupdt_sync,
    output logic [INFO_W-1:0] o_botinfo_snap,
    output logic [CNT_W-1:0]  o_upd_cnt,
    output logic [CNT_W-1:0]  o_ovr_cnt,
    output logic              o_timeout
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PEND     = 2'd1;
    localparam logic [1:0] ST_ACK_HOLD = 2'd2;

    // Timeout compare value; only meaningful when the timeout is enabled.
    localparam bit              TO_EN   = (ACK_TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST = (ACK_TIMEOUT == 0) ? '0 : TO_W'(ACK_TIMEOUT - 1);

    // Overrun counter never wraps: it sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              upd_q;
    logic              evt;
    logic              defer_vld;
    logic              defer_vld_nxt;
    logic [INFO_W-1:0] defer_info;
    logic [INFO_W-1:0] defer_info_nxt;
    logic [INFO_W-1:0] snap_nxt;
    logic              ovr_inc;
    logic              pend_entry;
    logic              pend_exit_ack;
    logic [TO_W-1:0]   to_cnt;

    // A strobe held high yields a single event; upd_q is cleared by reset so a
    // strobe held through reset release still produces one event.
    assign evt = i_upd_sysregs & ~upd_q;

    // Request level is a decode of the registered state, so it is glitch-free.
    assign o_botupdt_sync = (state == ST_PEND);

    always_comb begin
        state_nxt      = state;
        snap_nxt       = o_botinfo_snap;
        defer_vld_nxt  = defer_vld;
        defer_info_nxt = defer_info;
        ovr_inc        = 1'b0;

        case (state)
            ST_IDLE: begin
                if (evt) begin
                    state_nxt = ST_PEND;
                    snap_nxt  = i_botinfo;
                end
            end

            ST_PEND: begin
                if (i_int_ack) begin
                    // Software is reading the current snapshot: a new update
                    // must not disturb it, so it goes to the one-deep buffer.
                    state_nxt = ST_ACK_HOLD;
                    if (evt) begin
                        defer_vld_nxt  = 1'b1;
                        defer_info_nxt = i_botinfo;
                    end
                end else if (evt) begin
                    // Not yet consumed: freshest data wins, old one is lost.
                    snap_nxt = i_botinfo;
                    ovr_inc  = 1'b1;
                end
            end

            ST_ACK_HOLD: begin
                if (evt) begin
                    defer_vld_nxt  = 1'b1;
                    defer_info_nxt = i_botinfo;
                    if (defer_vld) begin
                        ovr_inc = 1'b1;
                    end
                end
                if (!i_int_ack) begin
                    if (defer_vld || evt) begin
                        // An update arriving on the release cycle is newer
                        // than anything in the buffer, so it bypasses it.
                        state_nxt     = ST_PEND;
                        snap_nxt      = evt ? i_botinfo : defer_info;
                        defer_vld_nxt = 1'b0;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign pend_entry    = (state_nxt == ST_PEND) && (state != ST_PEND);
    assign pend_exit_ack = (state == ST_PEND) && (state_nxt == ST_ACK_HOLD);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= ST_IDLE;
            upd_q          <= 1'b0;
            o_botinfo_snap <= '0;
            defer_vld      <= 1'b0;
            defer_info     <= '0;
            o_upd_cnt      <= '0;
            o_ovr_cnt      <= '0;
            to_cnt         <= '0;
            o_timeout      <= 1'b0;
        end else begin
            state          <= state_nxt;
            upd_q          <= i_upd_sysregs;
            o_botinfo_snap <= snap_nxt;
            defer_vld      <= defer_vld_nxt;
            defer_info     <= defer_info_nxt;

            if (evt) begin
                o_upd_cnt <= o_upd_cnt + CNT_W'(1);
            end

            if (ovr_inc) begin
                o_ovr_cnt <= sat_inc(o_ovr_cnt);
            end

            // to_cnt counts cycles spent in the current PEND visit.
            if (pend_entry) begin
                to_cnt <= '0;
            end else if (state == ST_PEND) begin
                to_cnt <= to_cnt + TO_W'(1);
            end

            // An acknowledge wins over a timeout that would fire on the same
            // edge; the flag only reports requests that are still unserved.
            if (pend_exit_ack) begin
                o_timeout <= 1'b0;
            end else if (TO_EN && (state == ST_PEND) && (to_cnt == TO_LAST)) begin
                o_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bot_upd_handshake.sv
module tb_bot_upd_handshake;

    localparam int INFO_W = 32;
    localparam int CNT_W  = 8;
    localparam int ACK_TO = 10;
    localparam int TO_W   = 24;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              upd = 1'b0;
    logic [INFO_W-1:0] info = '0;
    logic              ack = 1'b0;
    logic              sync;
    logic [INFO_W-1:0] snap;
    logic [CNT_W-1:0]  upd_cnt;
    logic [CNT_W-1:0]  ovr_cnt;
    logic              timeout;

    bot_upd_handshake #(
        .INFO_W(INFO_W), .CNT_W(CNT_W), .ACK_TIMEOUT(ACK_TO), .TO_W(TO_W)
    ) dut (
        .clk(clk), .rstn(rstn), .i_upd_sysregs(upd), .i_botinfo(info),
        .i_int_ack(ack), .o_botupdt_sync(sync), .o_botinfo_snap(snap),
        .o_upd_cnt(upd_cnt), .o_ovr_cnt(ovr_cnt), .o_timeout(timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, want, $time);
        end
    endtask

    // ---------------- reference model (software-visible behaviour) --------
    typedef struct {
        bit          sync;
        logic [31:0] snap;
        int          upd;
        int          ovr;
        bit          to;
    } exp_t;

    exp_t exp_q[$];

    bit          m_req;     // software currently sees a request
    bit          m_hold;    // software is holding its acknowledge
    logic [31:0] m_snap;
    logic [31:0] m_buf[$];  // updates waiting behind the acknowledge (max 1 kept)
    int          m_upd, m_ovr, m_age;
    bit          m_to, m_prev;

    task automatic model_reset();
        m_req = 0; m_hold = 0; m_snap = '0; m_buf.delete();
        m_upd = 0; m_ovr = 0; m_age = 0; m_to = 0; m_prev = 0;
    endtask

    task automatic lose_one();
        if (m_ovr < CNT_MAX) m_ovr++;
    endtask

    task automatic model_step(input bit u, input logic [31:0] inf, input bit a);
        bit e;
        e = u && !m_prev;
        m_prev = u;
        if (e) m_upd = (m_upd + 1) % (CNT_MAX + 1);
        if (!m_req && !m_hold) begin
            if (e) begin m_req = 1; m_snap = inf; m_age = 0; end
        end else if (m_req) begin
            if (a) begin
                m_req = 0; m_hold = 1; m_to = 0;
                if (e) m_buf.push_back(inf);
            end else begin
                if (e) begin m_snap = inf; lose_one(); end
                m_age++;
                if (ACK_TO != 0 && m_age >= ACK_TO) m_to = 1;
            end
        end else begin
            if (e) begin
                if (m_buf.size() > 0) begin lose_one(); m_buf.delete(); end
                m_buf.push_back(inf);
            end
            if (!a) begin
                m_hold = 0;
                if (m_buf.size() > 0) begin
                    m_snap = m_buf.pop_front(); m_req = 1; m_age = 0;
                end
            end
        end
    endtask

    // Called at a falling edge; returns at the next falling edge, after the
    // DUT has taken the rising edge in between.
    task automatic step(input bit u, input logic [31:0] inf, input bit a);
        exp_t x;
        upd = u; info = inf; ack = a;
        model_step(u, inf, a);
        x.sync = m_req; x.snap = m_snap; x.upd = m_upd; x.ovr = m_ovr; x.to = m_to;
        exp_q.push_back(x);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #2;
        chk("rst_sync", sync, 0);
        chk("rst_snap", snap, 0);
        chk("rst_upd_cnt", upd_cnt, 0);
        chk("rst_ovr_cnt", ovr_cnt, 0);
        chk("rst_timeout", timeout, 0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // ---------------- monitor ---------------------------------------------
    exp_t mon_e;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("sb_sync", sync, mon_e.sync);
            chk("sb_snap", snap, mon_e.snap);
            chk("sb_upd_cnt", upd_cnt, mon_e.upd);
            chk("sb_ovr_cnt", ovr_cnt, mon_e.ovr);
            chk("sb_timeout", timeout, mon_e.to);
        end
    end

    // ---------------- stimulus --------------------------------------------
    initial begin
        bit a_r;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // 1: single pulse from idle
        step(1, 32'h1234_5678, 0);
        chk("t1_sync", sync, 1);
        chk("t1_snap", snap, 32'h1234_5678);
        chk("t1_upd_cnt", upd_cnt, 1);
        step(0, 0, 0);

        // 2: two more updates while pending, no ack
        step(1, 32'hA, 0); step(0, 0, 0);
        step(1, 32'hB, 0); step(0, 0, 0);
        chk("t2_snap", snap, 32'hB);
        chk("t2_ovr_cnt", ovr_cnt, 2);
        chk("t2_sync", sync, 1);

        // 3: ack with a coincident update, then release
        step(1, 32'hC, 1);
        chk("t3_sync_ack", sync, 0);
        chk("t3_snap_hold", snap, 32'hB);
        step(0, 0, 0);
        chk("t3_sync_rel", sync, 1);
        chk("t3_snap_rel", snap, 32'hC);
        chk("t3_ovr_cnt", ovr_cnt, 2);

        // 4: three updates while ack held
        step(0, 0, 1);
        step(1, 32'hD1, 1); step(0, 0, 1);
        step(1, 32'hD2, 1); step(0, 0, 1);
        step(1, 32'hD3, 1); step(0, 0, 1);
        chk("t4_ovr_cnt", ovr_cnt, 4);
        chk("t4_snap_hold", snap, 32'hC);
        step(0, 0, 0);
        chk("t4_sync", sync, 1);
        chk("t4_snap", snap, 32'hD3);
        step(0, 0, 1);
        step(0, 0, 0);

        // 5: ack timeout
        do_reset();
        step(1, 32'h55, 0);
        repeat (9) step(0, 0, 0);
        chk("t5_timeout_early", timeout, 0);
        step(0, 0, 0);
        chk("t5_timeout", timeout, 1);
        step(0, 0, 1);
        chk("t5_timeout_clr", timeout, 0);
        step(0, 0, 0);

        // 6: held strobe, reset mid-pending with strobe held, saturation
        do_reset();
        repeat (50) step(1, 32'h66, 0);
        chk("t6_upd_cnt", upd_cnt, 1);
        do_reset();
        step(1, 32'h77, 0);
        chk("t6_rel_upd_cnt", upd_cnt, 1);
        chk("t6_rel_sync", sync, 1);
        for (int i = 0; i < 300; i++) begin
            step(0, 0, 0);
            step(1, $urandom, 0);
        end
        chk("t6_ovr_sat", ovr_cnt, CNT_MAX);

        // random traffic
        do_reset();
        a_r = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) a_r = ~a_r;
            step($urandom_range(0, 2) == 0, $urandom, a_r);
        end
        repeat (3) step(0, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
